vector_corr_gen: RTL and testbench

- Upstream stage of the unitary-ESPRIT vector accumulators.
- Takes per-bin complex samples from two antenna channels, streamed one bin per valid cycle in frames of VECTOR_LEN bins.
- Produces the three covariance terms r11 = |x1|^2, r22 = |x2|^2, r12 = x1*conj(x2). Each term drives its own signed_vector_acc instance; r12 uses two instances.
- Generates the new_acc pulse that starts each accumulation period of ACC_LEN frames.

---
 rtl/uesprit_pkg.sv | 14 +
 rtl/vector_corr_gen_if.sv | 35 +++
 rtl/cmult_conj.sv | 119 +++++++++++
 rtl/vector_corr_gen.sv | 149 ++++++++++++++
 tb/tb_vector_corr_gen.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uesprit_pkg.sv
// Shared constants and width helpers for the unitary-ESPRIT covariance front end.
package uesprit_pkg;

    // Full-precision width of a sum of two DIN-bit signed products.
    function automatic int unsigned cmult_conj_w(input int unsigned din_w);
        return 2 * din_w + 1;
    endfunction

    localparam int unsigned DIN_WIDTH_DEF = 16;
    localparam int unsigned PROD_WIDTH    = 2 * DIN_WIDTH_DEF + 1;
    localparam int unsigned PIPE_LAT      = 3;
    localparam int unsigned ACC_LEN_W     = 16;

endpackage

// File: rtl/vector_corr_gen_if.sv
// Sample-in / covariance-out bundle of vector_corr_gen.
interface vector_corr_gen_if
    import uesprit_pkg::*;
#(
    parameter int unsigned DIN_WIDTH  = 16,
    parameter int unsigned DOUT_WIDTH = 33
) ();

    logic signed [DIN_WIDTH-1:0]  din1_re;
    logic signed [DIN_WIDTH-1:0]  din1_im;
    logic signed [DIN_WIDTH-1:0]  din2_re;
    logic signed [DIN_WIDTH-1:0]  din2_im;
    logic                         din_valid;
    logic                         sync_in;
    logic [ACC_LEN_W-1:0]         acc_len;

    logic signed [DOUT_WIDTH-1:0] r11;
    logic signed [DOUT_WIDTH-1:0] r22;
    logic signed [DOUT_WIDTH-1:0] r12_re;
    logic signed [DOUT_WIDTH-1:0] r12_im;
    logic                         dout_valid;
    logic                         new_acc;
    logic                         sync_err;

    modport master (
        output din1_re, din1_im, din2_re, din2_im, din_valid, sync_in, acc_len,
        input  r11, r22, r12_re, r12_im, dout_valid, new_acc, sync_err
    );

    modport slave (
        input  din1_re, din1_im, din2_re, din2_im, din_valid, sync_in, acc_len,
        output r11, r22, r12_re, r12_im, dout_valid, new_acc, sync_err
    );

endinterface

// File: rtl/cmult_conj.sv
// Three-stage a*conj(b): register inputs, register products, register sums.
// CORR_ROUND_EN adds round-half-up and an arithmetic right shift by SHIFT on the sums.
module cmult_conj
    import uesprit_pkg::*;
#(
    parameter int unsigned DIN_WIDTH  = 16,
    parameter int unsigned DOUT_WIDTH = 33,
    parameter int unsigned SHIFT      = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic signed [DIN_WIDTH-1:0]  a_re,
    input  logic signed [DIN_WIDTH-1:0]  a_im,
    input  logic signed [DIN_WIDTH-1:0]  b_re,
    input  logic signed [DIN_WIDTH-1:0]  b_im,
    output logic                         out_valid,
    output logic signed [DOUT_WIDTH-1:0] out_re,
    output logic signed [DOUT_WIDTH-1:0] out_im
);

    localparam int unsigned MUL_W = 2 * DIN_WIDTH;
    localparam int unsigned SUM_W = cmult_conj_w(DIN_WIDTH);

    if (DOUT_WIDTH + SHIFT < SUM_W) begin : g_width_chk
        $error("cmult_conj: DOUT_WIDTH too narrow for DIN_WIDTH and SHIFT");
    end

`ifdef CORR_ROUND_EN
    localparam int unsigned RND_W = SUM_W + 1;
    localparam logic signed [RND_W-1:0] RND_HALF = (SHIFT == 0) ? '0 : RND_W'(1) << (SHIFT - 1);

    // One guard bit keeps the rounding add from overflowing at the most positive sum.
    function automatic logic signed [DOUT_WIDTH-1:0] scale(input logic signed [SUM_W-1:0] s);
        logic signed [RND_W-1:0] t;
        t = RND_W'(s) + RND_HALF;
        return DOUT_WIDTH'(t >>> SHIFT);
    endfunction
`else
    function automatic logic signed [DOUT_WIDTH-1:0] scale(input logic signed [SUM_W-1:0] s);
        return DOUT_WIDTH'(s);
    endfunction
`endif

    logic [PIPE_LAT-1:0]          vld_q, vld_d;
    logic signed [DIN_WIDTH-1:0]  a_re_q, a_re_d, a_im_q, a_im_d;
    logic signed [DIN_WIDTH-1:0]  b_re_q, b_re_d, b_im_q, b_im_d;
    logic signed [MUL_W-1:0]      p_rr_q, p_rr_d, p_ii_q, p_ii_d;
    logic signed [MUL_W-1:0]      p_ir_q, p_ir_d, p_ri_q, p_ri_d;
    logic signed [DOUT_WIDTH-1:0] re_q, re_d, im_q, im_d;
    logic signed [SUM_W-1:0]      re_sum_c, im_sum_c;

    // Each stage loads only behind its own valid bit so idle cycles hold the last result.
    always_comb begin
        vld_d    = {vld_q[PIPE_LAT-2:0], in_valid};
        a_re_d   = a_re_q;
        a_im_d   = a_im_q;
        b_re_d   = b_re_q;
        b_im_d   = b_im_q;
        p_rr_d   = p_rr_q;
        p_ii_d   = p_ii_q;
        p_ir_d   = p_ir_q;
        p_ri_d   = p_ri_q;
        re_d     = re_q;
        im_d     = im_q;
        re_sum_c = SUM_W'(p_rr_q) + SUM_W'(p_ii_q);
        im_sum_c = SUM_W'(p_ir_q) - SUM_W'(p_ri_q);

        if (in_valid) begin
            a_re_d = a_re;
            a_im_d = a_im;
            b_re_d = b_re;
            b_im_d = b_im;
        end
        if (vld_q[0]) begin
            p_rr_d = MUL_W'(a_re_q) * MUL_W'(b_re_q);
            p_ii_d = MUL_W'(a_im_q) * MUL_W'(b_im_q);
            p_ir_d = MUL_W'(a_im_q) * MUL_W'(b_re_q);
            p_ri_d = MUL_W'(a_re_q) * MUL_W'(b_im_q);
        end
        if (vld_q[1]) begin
            re_d = scale(re_sum_c);
            im_d = scale(im_sum_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            a_re_q <= '0;
            a_im_q <= '0;
            b_re_q <= '0;
            b_im_q <= '0;
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ir_q <= '0;
            p_ri_q <= '0;
            re_q   <= '0;
            im_q   <= '0;
        end else begin
            vld_q  <= vld_d;
            a_re_q <= a_re_d;
            a_im_q <= a_im_d;
            b_re_q <= b_re_d;
            b_im_q <= b_im_d;
            p_rr_q <= p_rr_d;
            p_ii_q <= p_ii_d;
            p_ir_q <= p_ir_d;
            p_ri_q <= p_ri_d;
            re_q   <= re_d;
            im_q   <= im_d;
        end
    end

    assign out_valid = vld_q[PIPE_LAT-1];
    assign out_re    = re_q;
    assign out_im    = im_q;

endmodule

// File: rtl/vector_corr_gen.sv
// Covariance-term generator (r11, r22, r12) with bin/frame tracking and new_acc generation.
// Optional macro CORR_ROUND_EN enables rounding and scaling by SHIFT on every output term.
module vector_corr_gen
    import uesprit_pkg::*;
#(
    parameter int unsigned DIN_WIDTH  = 16,
    parameter int unsigned DOUT_WIDTH = 33,
    parameter int unsigned VECTOR_LEN = 64,
    parameter int unsigned SHIFT      = 0
) (
    input  logic             clk,
    input  logic             rst,
    vector_corr_gen_if.slave bus
);

    localparam int unsigned BIN_W = $clog2(VECTOR_LEN);

    if (VECTOR_LEN < 4 || (VECTOR_LEN & (VECTOR_LEN - 1)) != 0) begin : g_len_chk
        $error("vector_corr_gen: VECTOR_LEN must be a power of two >= 4");
    end

    logic [BIN_W-1:0]     bin_q, bin_d, bin_eff_c;
    logic [ACC_LEN_W-1:0] frame_q, frame_d, frame_eff_c;
    logic [ACC_LEN_W-1:0] acc_len_l_q, acc_len_l_d;
    logic                 start_pending_q, start_pending_d, pending_eff_c;
    logic                 sync_err_q, sync_err_d;
    logic [PIPE_LAT-1:0]  tag_q, tag_d;
    logic                 start_c;
    logic                 r11_im_unused, r22_im_unused;
    logic                 r11_vld_unused, r22_vld_unused;
    logic signed [DOUT_WIDTH-1:0] r11_im_w_unused, r22_im_w_unused;

    // frame_q counts frames completed since the period start; a period closes at bin 0
    // once acc_len_l frames have finished, or immediately after a realignment.
    always_comb begin
        bin_d           = bin_q;
        frame_d         = frame_q;
        acc_len_l_d     = acc_len_l_q;
        start_pending_d = start_pending_q;
        sync_err_d      = sync_err_q;
        bin_eff_c       = bin_q;
        frame_eff_c     = frame_q;
        pending_eff_c   = start_pending_q;
        start_c         = 1'b0;

        if (bus.din_valid) begin
            if (bus.sync_in) begin
                bin_eff_c = '0;
                if (bin_q != '0) begin
                    sync_err_d    = 1'b1;
                    frame_eff_c   = '0;
                    pending_eff_c = 1'b1;
                end
            end

            start_c = (bin_eff_c == '0) && (pending_eff_c || (frame_eff_c == acc_len_l_q));

            bin_d           = bin_eff_c + BIN_W'(1);
            frame_d         = frame_eff_c;
            start_pending_d = pending_eff_c;

            if (start_c) begin
                frame_d         = '0;
                acc_len_l_d     = (bus.acc_len == '0) ? ACC_LEN_W'(1) : bus.acc_len;
                start_pending_d = 1'b0;
            end else if (bin_eff_c == BIN_W'(VECTOR_LEN - 1)) begin
                frame_d = frame_eff_c + ACC_LEN_W'(1);
            end
        end

        tag_d = {tag_q[PIPE_LAT-2:0], start_c};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q           <= '0;
            frame_q         <= '0;
            acc_len_l_q     <= ACC_LEN_W'(1);
            start_pending_q <= 1'b1;
            sync_err_q      <= 1'b0;
            tag_q           <= '0;
        end else begin
            bin_q           <= bin_d;
            frame_q         <= frame_d;
            acc_len_l_q     <= acc_len_l_d;
            start_pending_q <= start_pending_d;
            sync_err_q      <= sync_err_d;
            tag_q           <= tag_d;
        end
    end

    cmult_conj #(
        .DIN_WIDTH (DIN_WIDTH),
        .DOUT_WIDTH(DOUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_r12 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.din_valid),
        .a_re     (bus.din1_re),
        .a_im     (bus.din1_im),
        .b_re     (bus.din2_re),
        .b_im     (bus.din2_im),
        .out_valid(bus.dout_valid),
        .out_re   (bus.r12_re),
        .out_im   (bus.r12_im)
    );

    // x*conj(x): the real part is |x|^2 and the imaginary part is identically zero.
    cmult_conj #(
        .DIN_WIDTH (DIN_WIDTH),
        .DOUT_WIDTH(DOUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_r11 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.din_valid),
        .a_re     (bus.din1_re),
        .a_im     (bus.din1_im),
        .b_re     (bus.din1_re),
        .b_im     (bus.din1_im),
        .out_valid(r11_vld_unused),
        .out_re   (bus.r11),
        .out_im   (r11_im_w_unused)
    );

    cmult_conj #(
        .DIN_WIDTH (DIN_WIDTH),
        .DOUT_WIDTH(DOUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_r22 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.din_valid),
        .a_re     (bus.din2_re),
        .a_im     (bus.din2_im),
        .b_re     (bus.din2_re),
        .b_im     (bus.din2_im),
        .out_valid(r22_vld_unused),
        .out_re   (bus.r22),
        .out_im   (r22_im_w_unused)
    );

    assign r11_im_unused = ^r11_im_w_unused;
    assign r22_im_unused = ^r22_im_w_unused;
    assign bus.new_acc   = tag_q[PIPE_LAT-1];
    assign bus.sync_err  = sync_err_q;

endmodule

// File: tb/tb_vector_corr_gen.sv
// Randomised bench for vector_corr_gen against a scoreboard of expected covariance terms.
module tb_vector_corr_gen;

    localparam int DIN_W  = 16;
    localparam int DOUT_W = 33;
    localparam int VLEN   = 64;
`ifdef CORR_ROUND_EN
    localparam int SHIFT  = 2;
`else
    localparam int SHIFT  = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vector_corr_gen_if #(.DIN_WIDTH(DIN_W), .DOUT_WIDTH(DOUT_W)) bus ();

    vector_corr_gen #(
        .DIN_WIDTH (DIN_W),
        .DOUT_WIDTH(DOUT_W),
        .VECTOR_LEN(VLEN),
        .SHIFT     (SHIFT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        longint r11;
        longint r22;
        longint rre;
        longint rim;
        bit     na;
        int     cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   n_sent = 0;
    int   n_na = 0;

    // Reference period state: bin index, frames finished in the period, pending start.
    int   m_bin;
    int   m_done;
    bit   m_pending;
    int   m_len;
    bit   m_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint scale(input longint v);
        return (v + ((longint'(1) << SHIFT) >>> 1)) >>> SHIFT;
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int re1, input int im1, input int re2, input int im2, input bit sync);
        exp_t e;
        bus.din1_re   = DIN_W'(re1);
        bus.din1_im   = DIN_W'(im1);
        bus.din2_re   = DIN_W'(re2);
        bus.din2_im   = DIN_W'(im2);
        bus.din_valid = 1'b1;
        bus.sync_in   = sync;

        if (sync && m_bin != 0) begin
            m_err     = 1'b1;
            m_pending = 1'b1;
            m_done    = 0;
        end
        if (sync) m_bin = 0;
        e.na = (m_bin == 0) && (m_pending || m_done == m_len);
        if (e.na) begin
            m_done    = 0;
            m_len     = (bus.acc_len == 0) ? 1 : int'(bus.acc_len);
            m_pending = 1'b0;
        end
        m_bin = (m_bin + 1) % VLEN;
        if (m_bin == 0) m_done++;

        e.r11 = scale(longint'(re1) * re1 + longint'(im1) * im1);
        e.r22 = scale(longint'(re2) * re2 + longint'(im2) * im2);
        e.rre = scale(longint'(re1) * re2 + longint'(im1) * im2);
        e.rim = scale(longint'(im1) * re2 - longint'(re1) * im2);
        e.cyc = cyc;
        q.push_back(e);
        n_sent++;

        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        bus.sync_in   = 1'b0;
    endtask

    task automatic send_rand(input bit sync);
        send(rnd16(), rnd16(), rnd16(), rnd16(), sync);
    endtask

    task automatic do_reset(input int ncyc);
        rst           = 1'b1;
        bus.din_valid = 1'b0;
        bus.sync_in   = 1'b0;
        repeat (ncyc) @(posedge clk);
        #1;
        q.delete();
        m_bin     = 0;
        m_done    = 0;
        m_pending = 1'b1;
        m_len     = 1;
        m_err     = 1'b0;
        check("rst_r11", bus.r11, 0);
        check("rst_r22", bus.r22, 0);
        check("rst_r12_re", bus.r12_re, 0);
        check("rst_r12_im", bus.r12_im, 0);
        check("rst_dout_valid", bus.dout_valid, 0);
        check("rst_new_acc", bus.new_acc, 0);
        check("rst_sync_err", bus.sync_err, 0);
        rst = 1'b0;
    endtask

    // Output monitor: every dout_valid pops one expected record, in order.
    always @(negedge clk) begin
        if (bus.dout_valid) begin
            n_out++;
            if (bus.new_acc) n_na++;
            if (q.size() == 0) begin
                check("spurious_out", bus.dout_valid, 0);
            end else begin
                mon_e = q.pop_front();
                check("r11", bus.r11, mon_e.r11);
                check("r22", bus.r22, mon_e.r22);
                check("r12_re", bus.r12_re, mon_e.rre);
                check("r12_im", bus.r12_im, mon_e.rim);
                check("new_acc", bus.new_acc, longint'(mon_e.na));
                check("latency", cyc, mon_e.cyc + 3);
            end
        end else begin
            check("new_acc_idle", bus.new_acc, 0);
        end
    end

    initial begin
        int out0;
        int sent0;
        bus.din1_re   = '0;
        bus.din1_im   = '0;
        bus.din2_re   = '0;
        bus.din2_im   = '0;
        bus.din_valid = 1'b0;
        bus.sync_in   = 1'b0;
        bus.acc_len   = 16'd2;
        do_reset(2);

        // Constant frame: every output identical, new_acc only on the first.
        n_na = 0;
        for (int b = 0; b < VLEN; b++) send(3, 4, 1, -2, b == 0);
        idle(4);
        check("s1_na_count", n_na, 1);
        check("s1_r11_hold", bus.r11, scale(25));
        check("s1_r12_im_hold", bus.r12_im, scale(10));

        // Seven continuous frames at acc_len=3.
        do_reset(1);
        bus.acc_len = 16'd3;
        n_na = 0;
        for (int f = 0; f < 7; f++)
            for (int b = 0; b < VLEN; b++) send_rand(b == 0);
        idle(4);
        check("s2_na_count", n_na, 3);

        // Most-negative corner on both channels.
        for (int b = 0; b < 8; b++) send(-32768, -32768, -32768, -32768, m_bin == 0);
        idle(4);
        check("s3_r11_corner", bus.r11, scale(longint'(1) << 31));
        check("s3_r12_re_corner", bus.r12_re, scale(longint'(1) << 31));
        check("s3_r12_im_corner", bus.r12_im, 0);

        // Misaligned sync at bin 17.
        do_reset(1);
        bus.acc_len = 16'd2;
        for (int b = 0; b < 17; b++) send_rand(b == 0);
        check("s4_sync_err_clean", bus.sync_err, 0);
        n_na = 0;
        send_rand(1'b1);
        check("s4_sync_err_set", bus.sync_err, 1);
        for (int b = 0; b < 2 * VLEN; b++) send_rand(m_bin == 0);
        idle(4);
        check("s4_sync_err_sticky", bus.sync_err, 1);
        check("s4_sync_err_model", bus.sync_err, longint'(m_err));
        check("s4_na_count", n_na, 2);

        // Random valid gaps and acc_len changes mid-period.
        out0  = n_out;
        sent0 = n_sent;
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 99) < 10) bus.acc_len = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) send_rand(m_bin == 0);
            else idle(1);
        end
        idle(6);
        check("s5_out_count", n_out - out0, n_sent - sent0);

        // Reset at bin 30: in-flight samples vanish, next bin 0 restarts the period.
        do_reset(1);
        bus.acc_len = 16'd1;
        for (int b = 0; b < 30; b++) send_rand(b == 0);
        do_reset(1);
        n_na = 0;
        for (int b = 0; b < 20; b++) send_rand(b == 0);
        idle(6);
        check("s6_na_count", n_na, 1);
        check("final_drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
